// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests and buffers
// fetched {pc, instr} entries in a FQ_DEPTH-entry queue feeding the ID stage.
module fetch_unit #(
  parameter int unsigned                  ADDR_WIDTH  = 32,
  parameter int unsigned                  INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]        RESET_PC    = '0,
  parameter int unsigned                  FQ_DEPTH    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic [ADDR_WIDTH-1:0]  id_next_pc,
  output logic [INSTR_WIDTH-1:0] id_instr
);

  localparam int unsigned           INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int unsigned           IDX_W       = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned           CNT_W       = $clog2(FQ_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INC      = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~(PC_INC - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0]      DEPTH_C     = CNT_W'(FQ_DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(FQ_DEPTH - 1);

  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  entry_pc    [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] entry_instr [FQ_DEPTH];
  logic [FQ_DEPTH-1:0]    filled;
  logic [IDX_W-1:0]       head;
  logic [IDX_W-1:0]       tail;
  logic [IDX_W-1:0]       fill_ptr;
  logic [CNT_W-1:0]       occ;
  logic [CNT_W-1:0]       unfilled;
  logic [CNT_W-1:0]       discard_cnt;

  logic credit_ok;
  logic alloc;
  logic fill;
  logic drop;
  logic pop;

  function automatic logic [IDX_W-1:0] bump(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // Credits come from registered state only, so a pop never frees a slot in the same cycle.
  assign credit_ok      = (occ + discard_cnt) < DEPTH_C;
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;

  assign alloc = imem_req_valid && imem_req_ready;
  assign drop  = imem_rsp_valid && (discard_cnt != '0);
  assign fill  = imem_rsp_valid && (discard_cnt == '0) && !redirect_valid;
  assign pop   = id_valid && id_ready && !redirect_valid;

  assign id_valid   = filled[head];
  assign id_pc      = id_valid ? entry_pc[head] : '0;
  assign id_next_pc = id_valid ? entry_pc[head] + PC_INC : '0;
  assign id_instr   = id_valid ? entry_instr[head] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      filled      <= '0;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      occ         <= '0;
      unfilled    <= '0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc & ALIGN_MASK;
      filled      <= '0;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      occ         <= '0;
      unfilled    <= '0;
      // Every request still in flight after this edge must be dropped on return.
      discard_cnt <= discard_cnt + unfilled - CNT_W'(imem_rsp_valid);
    end else begin
      if (alloc) begin
        pc   <= pc + PC_INC;
        tail <= bump(tail);
      end
      if (drop) begin
        discard_cnt <= discard_cnt - CNT_W'(1);
      end
      if (fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= bump(fill_ptr);
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= bump(head);
      end
      occ      <= occ + CNT_W'(alloc) - CNT_W'(pop);
      unfilled <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
    end
  end

  // NOTE: payload storage has no reset; the filled bits alone decide validity and gate the outputs.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entry_pc[tail] <= pc;
    end
    if (fill) begin
      entry_instr[fill_ptr] <= imem_rsp_data;
    end
  end

  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((discard_cnt != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-randomised memory model plus a program-order PC model
// checking every request address and every instruction handed to ID.
module tb_fetch_unit;

  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 3;
  localparam logic [31:0] RPC   = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [IW-1:0] imem_rsp_data = '0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_next_pc;
  logic [IW-1:0] id_instr;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (RPC),
    .FQ_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_next_pc    (id_next_pc),
    .id_instr      (id_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int total = 0;
  int bad   = 0;

  mreq_t       mem_q[$];
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, idr_pct = 100;
  logic        redir_now = 1'b0;
  logic [31:0] redir_target = '0;
  logic [31:0] exp_req_pc = RPC, exp_id_pc = RPC;
  int          last_due = 0, sc = 0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        last_req_valid = 1'b0;
  int          acc_cnt = 0, pop_cnt = 0, first_idv = -1;
  logic        got_acc = 1'b0, got_pop = 1'b0;
  logic [31:0] first_acc_addr = '0, first_pop_pc = '0, first_pop_next = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic arm();
    got_acc = 1'b0;
    got_pop = 1'b0;
  endtask

  // One clock cycle: entered at a falling edge, drives inputs, checks, waits for the next falling edge.
  task automatic step();
    int lat;
    int due;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    id_ready       = ($urandom_range(99) < idr_pct);
    redirect_valid = redir_now;
    redirect_pc    = redir_target;
    redir_now      = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= sc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (redirect_valid) check("req_withdrawn", imem_req_valid, 0);
    else if (prev_pending) begin
      check("req_hold_valid", imem_req_valid, 1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
    check("credit_bound", mem_q.size() <= DEPTH, 1);
    if (id_valid && first_idv < 0) first_idv = sc;
    if (id_valid && id_ready && !redirect_valid) begin
      pop_cnt++;
      check("id_pc", id_pc, exp_id_pc);
      check("id_instr", id_instr, instr_of(exp_id_pc));
      check("id_next_pc", id_next_pc, exp_id_pc + 32'd4);
      if (!got_pop) begin
        got_pop        = 1'b1;
        first_pop_pc   = id_pc;
        first_pop_next = id_next_pc;
      end
      exp_id_pc += 32'd4;
    end
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      acc_cnt++;
      if (!got_acc) begin
        got_acc        = 1'b1;
        first_acc_addr = imem_req_addr;
      end
      lat = $urandom_range(lat_max, lat_min);
      due = sc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: imem_req_addr, due: due});
      exp_req_pc += 32'd4;
    end
    if (redirect_valid) begin
      exp_req_pc = redirect_pc & ~32'h3;
      exp_id_pc  = redirect_pc & ~32'h3;
    end
    prev_pending   = imem_req_valid && !imem_req_ready;
    prev_addr      = imem_req_addr;
    last_req_valid = imem_req_valid;
    sc++;
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redir_now    = 1'b1;
    redir_target = a;
    step();
  endtask

  // Asserts reset immediately, checks outputs, feeds stale responses, releases at a falling edge.
  task automatic do_reset(input int cycles);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_next_pc", id_next_pc, 0);
    check("rst_id_instr", id_instr, 0);
    repeat (cycles) begin
      @(negedge clk);
      imem_rsp_valid = (mem_q.size() != 0);
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (mem_q.size() != 0) void'(mem_q.pop_front());
    end
    mem_q.delete();
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    rst            = 1'b0;
    exp_req_pc     = RPC;
    exp_id_pc      = RPC;
    last_due       = 0;
    sc             = 0;
    prev_pending   = 1'b0;
  endtask

  initial begin
    do_reset(3);

    // Streaming from reset with single-cycle memory.
    first_idv = -1; acc_cnt = 0; pop_cnt = 0; arm();
    repeat (22) step();
    check("t1_first_id_cycle", first_idv, 2);
    check("t1_first_pop_pc", first_pop_pc, 32'h0);
    check("t1_accepts", acc_cnt, 22);
    check("t1_pops", pop_cnt, 20);

    // ID stall: only FQ_DEPTH requests go out, head stays put, then drains in order.
    idr_pct = 0; acc_cnt = 0;
    redirect_to(32'h200);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4 || i == 9) begin
        check("t2_head_valid", id_valid, 1);
        check("t2_head_pc", id_pc, 32'h200);
        check("t2_head_instr", id_instr, instr_of(32'h200));
      end
    end
    check("t2_accepts", acc_cnt, DEPTH);
    check("t2_req_stopped", last_req_valid, 0);
    idr_pct = 100; pop_cnt = 0;
    repeat (10) step();
    check("t2_drain_pops", pop_cnt, 10);

    // Redirect with 3-cycle memory and requests in flight; unaligned target.
    lat_min = 3; lat_max = 3;
    repeat (6) step();
    arm();
    redirect_to(32'h103);
    repeat (14) step();
    check("t3_first_req", first_acc_addr, 32'h100);
    check("t3_first_pop", first_pop_pc, 32'h100);

    // Memory not ready: request held, PC not advanced.
    lat_min = 1; lat_max = 1; rdy_pct = 0;
    repeat (6) step();
    check("t4_req_still_valid", last_req_valid, 1);
    arm();
    rdy_pct = 100;
    step();
    check("t4_accept_addr", first_acc_addr, prev_addr);
    check("t4_accept_is_model_pc", first_acc_addr + 32'd4, exp_req_pc);

    // PC wrap at the top of the address space.
    arm();
    redirect_to(32'hFFFF_FFFC);
    repeat (10) step();
    check("t5_first_pop_pc", first_pop_pc, 32'hFFFF_FFFC);
    check("t5_first_next_pc", first_pop_next, 32'h0);

    // Mid-cycle reset with a full queue and requests in flight.
    idr_pct = 0; lat_min = 3; lat_max = 3;
    repeat (8) step();
    #3;
    do_reset(4);
    lat_min = 1; lat_max = 1; idr_pct = 100; rdy_pct = 100;
    arm(); first_idv = -1;
    repeat (6) step();
    check("t6_first_req", first_acc_addr, RPC);
    check("t6_first_id_cycle", first_idv, 2);
    check("t6_first_pop", first_pop_pc, RPC);

    // Random traffic: variable latency, backpressure and redirects.
    lat_min = 1; lat_max = 4; rdy_pct = 70; idr_pct = 70; pop_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) begin
        redir_now    = 1'b1;
        redir_target = $urandom;
      end
      step();
    end
    check("rand_progress", pop_cnt >= 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
